// File: rtl/hi_lo_muldiv_unit.sv
//------------------------------------------------------------------------------
// Module      : hi_lo_muldiv_unit
// Description : Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO
//               registers and single-cycle MTHI/MTLO writes.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hi_lo_muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo,
  output logic                  busy,
  output logic                  done
);

  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  localparam logic [2:0]    c_op_mult  = 3'b000;
  localparam logic [2:0]    c_op_multu = 3'b001;
  localparam logic [2:0]    c_op_div   = 3'b010;
  localparam logic [2:0]    c_op_divu  = 3'b011;
  localparam logic [2:0]    c_op_mthi  = 3'b100;
  localparam logic [2:0]    c_op_mtlo  = 3'b101;
  localparam logic [CW-1:0] c_last     = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t          r_state;
  logic [DW-1:0]   r_hi;
  logic [DW-1:0]   r_lo;
  logic            r_busy;
  logic            r_done;
  logic [2*DW-1:0] r_acc;
  logic [DW-1:0]   r_opnd;
  logic            r_is_div;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_div0;
  logic [CW-1:0]   r_count;

  // Operand capture: magnitudes for signed ops, unsigned values otherwise.
  logic            w_signed;
  logic            w_is_div;
  logic [DW-1:0]   w_mag_a;
  logic [DW-1:0]   w_mag_b;

  assign w_signed = ~op[0];
  assign w_is_div = op[1];
  assign w_mag_a  = (w_signed && a[DW-1]) ? (~a + 1'b1) : a;
  assign w_mag_b  = (w_signed && b[DW-1]) ? (~b + 1'b1) : b;

  // Shift-add multiply step: acc = {partial product high, remaining multiplier}.
  logic [DW:0]     w_mul_sum;
  logic [2*DW-1:0] w_mul_next;

  assign w_mul_sum  = {1'b0, r_acc[2*DW-1:DW]} + (r_acc[0] ? {1'b0, r_opnd} : {(DW+1){1'b0}});
  assign w_mul_next = {w_mul_sum, r_acc[DW-1:1]};

  // Restoring divide step: acc = {partial remainder, dividend/quotient bits}.
  logic [DW:0]     w_div_shift;
  logic [DW:0]     w_div_diff;
  logic            w_div_ge;
  logic [DW-1:0]   w_div_rem;
  logic [2*DW-1:0] w_div_next;

  assign w_div_shift = {r_acc[2*DW-1:DW], r_acc[DW-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
  assign w_div_rem   = w_div_ge ? w_div_diff[DW-1:0] : w_div_shift[DW-1:0];
  assign w_div_next  = {w_div_rem, r_acc[DW-2:0], w_div_ge};

  // Sign correction. With a zero divisor every step subtracts nothing, so the
  // remainder ends up holding |A| and the remainder-sign fix restores A itself.
  logic [2*DW-1:0] w_prod;
  logic [DW-1:0]   w_quot;
  logic [DW-1:0]   w_rem;
  logic [DW-1:0]   w_fix_hi;
  logic [DW-1:0]   w_fix_lo;

  assign w_prod   = r_neg_q ? (~r_acc + 1'b1) : r_acc;
  assign w_quot   = r_acc[DW-1:0];
  assign w_rem    = r_acc[2*DW-1:DW];
  assign w_fix_hi = r_is_div ? (r_neg_r ? (~w_rem + 1'b1) : w_rem) : w_prod[2*DW-1:DW];
  assign w_fix_lo = r_is_div ? (r_div0 ? {DW{1'b1}} : (r_neg_q ? (~w_quot + 1'b1) : w_quot))
                             : w_prod[DW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_count  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            case (op)
              c_op_mthi: r_hi <= a;
              c_op_mtlo: r_lo <= a;
              c_op_mult, c_op_multu, c_op_div, c_op_divu: begin
                r_acc    <= {{DW{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
                r_opnd   <= w_is_div ? w_mag_b : w_mag_a;
                r_is_div <= w_is_div;
                r_neg_q  <= w_signed && (a[DW-1] ^ b[DW-1]);
                r_neg_r  <= w_signed && a[DW-1];
                r_div0   <= (b == '0);
                r_count  <= '0;
                r_busy   <= 1'b1;
                r_state  <= S_ITER;
              end
              default: ;
            endcase
          end
        end
        S_ITER: begin
          r_acc   <= r_is_div ? w_div_next : w_mul_next;
          r_count <= r_count + 1'b1;
          if (r_count == c_last) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_hi    <= w_fix_hi;
          r_lo    <= w_fix_lo;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign busy = r_busy;
  assign done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_hi_lo_muldiv_unit.sv
//------------------------------------------------------------------------------
// Module      : tb_hi_lo_muldiv_unit
// Description : Self-checking bench for hi_lo_muldiv_unit.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_hi_lo_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  hi_lo_muldiv_unit #(.DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic with truncating signed division.
  function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                inout logic [31:0] h, inout logic [31:0] l);
    longint      sx;
    longint      sy;
    longint      q;
    longint      r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      3'd0: begin p = 64'(sx * sy); h = p[63:32]; l = p[31:0]; end
      3'd1: begin p = {32'b0, x} * {32'b0, y}; h = p[63:32]; l = p[31:0]; end
      3'd2: begin
        if (y == 32'd0) begin h = x; l = 32'hFFFFFFFF; end
        else begin q = sx / sy; r = sx % sy; l = q[31:0]; h = r[31:0]; end
      end
      3'd3: begin
        if (y == 32'd0) begin h = x; l = 32'hFFFFFFFF; end
        else begin l = x / y; h = x % y; end
      end
      3'd4: h = x;
      3'd5: l = x;
      default: ;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge of the Done cycle.
  task automatic long_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eh, input logic [31:0] el, input int mthi_at,
                         input string tag);
    int   n;
    logic held;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk({tag, " done_low_at_start"}, 64'(done), 64'd0);
    n    = 0;
    held = 1'b1;
    while (busy === 1'b1 && n < 100) begin
      n++;
      if (hi !== m_hi || lo !== m_lo) held = 1'b0;
      if (n == mthi_at) begin
        start = 1'b1; op = 3'd4; a = 32'hDEADBEEF;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, " busy_cycles"}, 64'(n), 64'd33);
    chk({tag, " hold"}, 64'(held), 64'd1);
    chk({tag, " done"}, 64'(done), 64'd1);
    chk({tag, " hi"}, 64'(hi), 64'(eh));
    chk({tag, " lo"}, 64'(lo), 64'(el));
    m_hi = eh;
    m_lo = el;
  endtask

  task automatic short_op(input logic [2:0] o, input logic [31:0] x, input string tag);
    start = 1'b1; op = o; a = x; b = $urandom;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    model(o, x, 32'd0, m_hi, m_lo);
    chk({tag, " hi"}, 64'(hi), 64'(m_hi));
    chk({tag, " lo"}, 64'(lo), 64'(m_lo));
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " done"}, 64'(done), 64'd0);
  endtask

  initial begin
    logic [2:0]  o;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] eh;
    logic [31:0] el;

    vecs[0] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1] = '{3'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2] = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[4] = '{3'd3, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
    vecs[5] = '{3'd2, 32'h80000000, 32'h00000000, 32'h80000000, 32'hFFFFFFFF};
    vecs[6] = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[7] = '{3'd3, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
    vecs[8] = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[9] = '{3'd1, 32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F};

    rst = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
    m_hi = '0; m_lo = '0;
    #12;
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back: each new start lands in the previous Done cycle.
    for (int i = 0; i < 10; i++) begin
      long_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, 0, $sformatf("vec%0d", i));
    end

    short_op(3'd5, 32'h00001234, "mtlo_idle");
    long_op(3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 5, "div_mthi_mid");
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);

    // Asynchronous reset in the middle of ITER.
    short_op(3'd4, 32'hA5A5A5A5, "mthi_pre");
    short_op(3'd5, 32'h5A5A5A5A, "mtlo_pre");
    start = 1'b1; op = 3'd1; a = 32'h12345678; b = 32'h9;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async hi", 64'(hi), 64'd0);
    chk("async lo", 64'(lo), 64'd0);
    chk("async busy", 64'(busy), 64'd0);
    chk("async done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    m_hi = '0; m_lo = '0;
    long_op(3'd1, 32'd3, 32'd5, 32'd0, 32'h0000000F, 0, "multu_after_rst");

    // Randomized traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 7) == 0) y = 32'd0;
      if ($urandom_range(0, 7) == 0) x = 32'h80000000;
      if (o < 3'd4) begin
        eh = m_hi; el = m_lo;
        model(o, x, y, eh, el);
        long_op(o, x, y, eh, el, 0, $sformatf("rnd%0d op%0d", i, o));
      end else begin
        short_op(o, x, $sformatf("rnd%0d op%0d", i, o));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
